// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC/SD SPI-mode master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    XFER     = 3'd1,
    CMD_SEND = 3'd2,
    CMD_POLL = 3'd3,
    DONE     = 3'd4
  } mmc_state_e;

  localparam logic [7:0] CRC_CMD0       = 8'h95;
  localparam logic [7:0] CRC_CMD8       = 8'h87;
  localparam logic [7:0] CRC_NONE       = 8'h01;
  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam logic [7:0] POLL_BYTE      = 8'hFF;

  // Only CMD0 and CMD8 are checked by the card before CRC is disabled,
  // so every other command carries a dummy CRC with the end bit set.
  function automatic logic [7:0] cmd_crc(input logic [5:0] idx);
    if (idx == 6'd0) begin
      return CRC_CMD0;
    end else if (idx == 6'd8) begin
      return CRC_CMD8;
    end
    return CRC_NONE;
  endfunction

endpackage

// File: rtl/mmc_spi_byte.sv
// SPI mode-0 byte engine: sclk divider plus 8-bit MSB-first shifter.
// Latency: done_o pulses 16*CLK_DIV cycles after start_i is sampled.
// Backpressure: none; start_i is ignored while a byte is in flight.
module mmc_spi_byte
  import mmc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  output logic [7:0] rx_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       di_o,
  input  logic       do_i
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          di_q, di_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          done_q, done_d;

  // Next state: rising edge samples MISO, falling edge advances MOSI or ends the byte.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    di_d     = di_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    if (start_i && !active_q) begin
      // MSB goes out immediately so it is settled a full half-period before the first rise.
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      di_d     = tx_i[7];
      tx_d     = {tx_i[6:0], 1'b1};
      rx_d     = '0;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], do_i};
        end else begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            // Last falling edge: stop here so no stray sclk pulse follows.
            active_d = 1'b0;
            done_d   = 1'b1;
            di_d     = POLL_BYTE[0];
            bit_d    = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            di_d  = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b1};
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // State registers; MOSI and sclk idle at 1 and 0 respectively.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      di_q     <= 1'b1;
      tx_q     <= 8'hFF;
      rx_q     <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      di_q     <= di_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
    end
  end

  assign rx_o   = rx_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign di_o   = di_q;

endmodule

// File: rtl/mmc_spi_ctrl.sv
// MMC/SD SPI master: raw byte transfers and 6-byte commands with R1 polling.
// Latency: raw byte done 16*CLK_DIV+1 cycles after start; each further byte adds the same.
// Backpressure: starts are only taken in IDLE; anything arriving while busy is dropped.
module mmc_spi_ctrl
  import mmc_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int RESP_POLL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_en,
  input  logic        byte_start,
  input  logic [7:0]  byte_tx,
  output logic [7:0]  byte_rx,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        mmc_cs,
  output logic        mmc_di,
  input  logic        mmc_do,
  output logic        mmc_sclk
);

  localparam logic [7:0] POLL_LAST = 8'(RESP_POLL - 1);

  mmc_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [39:0] frame_q, frame_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  byte_rx_q, byte_rx_d;
  logic        cs_q, cs_d;

  logic        eng_start;
  logic [7:0]  eng_tx;
  logic [7:0]  eng_rx;
  logic        eng_done;
  logic        poll_last;

  assign poll_last = (cnt_q == POLL_LAST);

  mmc_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (eng_start),
    .tx_i    (eng_tx),
    .rx_o    (eng_rx),
    .done_o  (eng_done),
    .sclk_o  (mmc_sclk),
    .di_o    (mmc_di),
    .do_i    (mmc_do)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a command outranks a raw byte requested in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = CMD_SEND;
        end else if (byte_start) begin
          state_d = XFER;
        end
      end
      XFER:     if (eng_done) state_d = DONE;
      CMD_SEND: if (eng_done && cnt_q == 8'd5) state_d = CMD_POLL;
      CMD_POLL: if (eng_done && (!eng_rx[7] || poll_last)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: status flags and the byte-engine launch for the next byte.
  always_comb begin
    busy      = (state_q == XFER) || (state_q == CMD_SEND) || (state_q == CMD_POLL);
    done      = (state_q == DONE);
    eng_start = 1'b0;
    eng_tx    = POLL_BYTE;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          eng_start = 1'b1;
          eng_tx    = {CMD_START_BITS, cmd_index};
        end else if (byte_start) begin
          eng_start = 1'b1;
          eng_tx    = byte_tx;
        end
      end
      CMD_SEND: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_tx    = (cnt_q == 8'd5) ? POLL_BYTE : frame_q[39:32];
        end
      end
      CMD_POLL: begin
        if (eng_done && eng_rx[7] && !poll_last) begin
          eng_start = 1'b1;
          eng_tx    = POLL_BYTE;
        end
      end
      default: ;
    endcase
  end

  // Datapath next state: frame shifter, byte/poll counter, response capture and card select.
  always_comb begin
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    byte_rx_d = eng_done ? eng_rx : byte_rx_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          // Byte 0 leaves straight from the inputs; the remaining five are held here.
          cnt_d     = '0;
          frame_d   = {cmd_arg, cmd_crc(cmd_index)};
          timeout_d = 1'b0;
        end
      end
      CMD_SEND: begin
        if (eng_done) begin
          if (cnt_q == 8'd5) begin
            cnt_d = '0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            frame_d = {frame_q[31:0], 8'h00};
          end
        end
      end
      CMD_POLL: begin
        if (eng_done) begin
          if (!eng_rx[7]) begin
            resp_d    = eng_rx;
            timeout_d = 1'b0;
          end else if (poll_last) begin
            resp_d    = POLL_BYTE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    // The card stays selected for the whole command regardless of cs_en.
    cs_d = ((state_d == CMD_SEND) || (state_d == CMD_POLL)) ? 1'b0 : ~cs_en;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      frame_q   <= '0;
      resp_q    <= 8'hFF;
      timeout_q <= 1'b0;
      byte_rx_q <= 8'h00;
      cs_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      byte_rx_q <= byte_rx_d;
      cs_q      <= cs_d;
    end
  end

  assign byte_rx = byte_rx_q;
  assign resp    = resp_q;
  assign timeout = timeout_q;
  assign mmc_cs  = cs_q;

endmodule

// File: tb/tb_mmc_spi_ctrl.sv
// Scoreboard bench for mmc_spi_ctrl with a bit-level card model.
// Latency: expectations carry the exact done cycle of each operation.
// Backpressure: the card model never stalls; unexpected bytes or done pulses are flagged.
module tb_mmc_spi_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int RESP_POLL = 8;
  localparam int BYTE_CYC  = 16 * CLK_DIV + 1;

  logic        clk;
  logic        reset_n;
  logic        cs_en;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic [7:0]  byte_rx;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;
  logic        mmc_cs;
  logic        mmc_di;
  logic        mmc_do;
  logic        mmc_sclk;

  mmc_spi_ctrl #(.CLK_DIV(CLK_DIV), .RESP_POLL(RESP_POLL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs_en      (cs_en),
    .byte_start (byte_start),
    .byte_tx    (byte_tx),
    .byte_rx    (byte_rx),
    .cmd_start  (cmd_start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .busy       (busy),
    .done       (done),
    .resp       (resp),
    .timeout    (timeout),
    .mmc_cs     (mmc_cs),
    .mmc_di     (mmc_di),
    .mmc_do     (mmc_do),
    .mmc_sclk   (mmc_sclk)
  );

  typedef struct {
    int         cyc;
    logic [7:0] rx;
    logic [7:0] resp;
    logic       to;
    logic       cs;
  } exp_done_t;

  exp_done_t  exp_done_q[$];
  logic [8:0] exp_mosi_q[$];   // {mmc_cs, byte} expected when each byte completes
  logic [7:0] card_q[$];       // bytes the card returns, in order

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         cyc        = 0;
  int         rise_cnt   = 0;
  int         mosi_bytes = 0;
  logic [7:0] m_resp     = 8'hFF;
  logic       m_to       = 1'b0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Card model: samples MOSI on sclk rise, moves MISO after sclk fall.
  initial begin : card_model
    logic       prev_sclk;
    logic       started;
    logic       from_q;
    int         bitidx;
    int         nbits;
    logic [7:0] cur;
    logic [7:0] sh;
    logic [8:0] e;
    mmc_do = 1'b1; prev_sclk = 1'b0; started = 1'b0; from_q = 1'b0;
    bitidx = 7; nbits = 0; cur = 8'hFF; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_sclk = 1'b0; started = 1'b0; from_q = 1'b0;
        bitidx = 7; nbits = 0; cur = 8'hFF; mmc_do = 1'b1;
      end else begin
        if (mmc_sclk && !prev_sclk) begin
          started = 1'b1;
          rise_cnt++;
          sh = {sh[6:0], mmc_di};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            mosi_bytes++;
            if (exp_mosi_q.size() == 0) begin
              n_checks++;
              $display("FAIL mosi_extra: got byte %02h, expected none", sh);
            end else begin
              e = exp_mosi_q.pop_front();
              chk("mosi_byte", 40'({mmc_cs, sh}), 40'(e));
            end
          end
        end else if (!mmc_sclk && prev_sclk) begin
          if (bitidx == 0) begin
            bitidx = 7; started = 1'b0; from_q = 1'b0;
          end else begin
            bitidx--;
          end
        end
        prev_sclk = mmc_sclk;
        if (!started && bitidx == 7 && !from_q) begin
          if (card_q.size() > 0) begin
            cur = card_q.pop_front();
            from_q = 1'b1;
          end else begin
            cur = 8'hFF;
          end
        end
        mmc_do = cur[bitidx];
      end
    end
  end

  // Done monitor: every done pulse must match the oldest expectation.
  initial begin : done_mon
    exp_done_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_extra: done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_done_q.pop_front();
          chk("done_cycle",   40'(cyc),     40'(e.cyc));
          chk("done_byte_rx", 40'(byte_rx), 40'(e.rx));
          chk("done_resp",    40'(resp),    40'(e.resp));
          chk("done_timeout", 40'(timeout), 40'(e.to));
          chk("done_cs",      40'(mmc_cs),  40'(e.cs));
          chk("done_busy",    40'(busy),    40'(0));
        end
      end
    end
  end

  task automatic raw_byte(input logic [7:0] tx, input logic [7:0] card);
    exp_done_t e;
    card_q.push_back(card);
    exp_mosi_q.push_back({1'b0, tx});
    @(negedge clk);
    byte_tx    = tx;
    byte_start = 1'b1;
    @(posedge clk);
    #1 byte_start = 1'b0;
    e.cyc = cyc + BYTE_CYC; e.rx = card; e.resp = m_resp; e.to = m_to; e.cs = ~cs_en;
    exp_done_q.push_back(e);
  endtask

  // pos = poll byte (1-based) carrying r1; 0 means the card never answers.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] r1, input int pos, input logic with_byte);
    exp_done_t  e;
    logic [7:0] fr [6];
    int         npoll;
    fr[0] = {2'b01, idx};
    fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
    fr[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
    npoll = (pos == 0) ? RESP_POLL : pos;
    for (int i = 0; i < 6; i++) begin
      card_q.push_back(8'hFF);
      exp_mosi_q.push_back({1'b0, fr[i]});
    end
    for (int i = 0; i < npoll; i++) begin
      card_q.push_back((pos != 0 && i == npoll - 1) ? r1 : 8'hFF);
      exp_mosi_q.push_back(9'h0FF);
    end
    @(negedge clk);
    cmd_index  = idx;
    cmd_arg    = arg;
    cmd_start  = 1'b1;
    byte_start = with_byte;
    byte_tx    = 8'h00;
    @(posedge clk);
    #1;
    cmd_start  = 1'b0;
    byte_start = 1'b0;
    cmd_index  = 6'h3F;          // must have been latched at acceptance
    cmd_arg    = 32'hDEADBEEF;
    if (pos != 0) begin m_resp = r1; m_to = 1'b0; end
    else begin m_resp = 8'hFF; m_to = 1'b1; end
    e.cyc = cyc + (6 + npoll) * BYTE_CYC; e.rx = m_resp; e.resp = m_resp; e.to = m_to; e.cs = ~cs_en;
    exp_done_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_done_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < budget) n_pass++;
    else begin
      $display("FAIL %s_wait: no completion within %0d cycles", name, budget);
      exp_done_q.delete();
    end
  endtask

  initial begin : stim
    int r0;
    int b0;
    int n;
    reset_n = 1'b0; cs_en = 1'b0; byte_start = 1'b0; cmd_start = 1'b0;
    byte_tx = 8'h00; cmd_index = 6'd0; cmd_arg = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs",      40'(mmc_cs),   40'(1));
    chk("rst_sclk",    40'(mmc_sclk), 40'(0));
    chk("rst_di",      40'(mmc_di),   40'(1));
    chk("rst_busy",    40'(busy),     40'(0));
    chk("rst_done",    40'(done),     40'(0));
    chk("rst_resp",    40'(resp),     40'(8'hFF));
    chk("rst_timeout", 40'(timeout),  40'(0));
    chk("rst_byte_rx", 40'(byte_rx),  40'(8'h00));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cs_off", 40'(mmc_cs), 40'(1));

    // Raw bytes with card select held by cs_en.
    cs_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cs_on", 40'(mmc_cs), 40'(0));
    r0 = rise_cnt;
    raw_byte(8'hA5, 8'h3C);
    wait_done("raw_a5", 200);
    chk("raw_rises", 40'(rise_cnt - r0), 40'(8));
    repeat (20) @(negedge clk);
    chk("raw_no_residual", 40'(rise_cnt - r0), 40'(8));
    chk("raw_sclk_idle",   40'(mmc_sclk), 40'(0));
    chk("raw_di_idle",     40'(mmc_di),   40'(1));
    raw_byte(8'h5A, 8'hC3);
    wait_done("raw_5a", 200);

    // CMD0: R1 on the third poll byte.
    cs_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("cs_released", 40'(mmc_cs), 40'(1));
    send_cmd(6'd0, 32'h0, 8'h01, 3, 1'b0);
    wait_done("cmd0", 1000);
    chk("cmd0_cs_after", 40'(mmc_cs), 40'(1));

    // CMD17 with a silent card: timeout after RESP_POLL bytes.
    send_cmd(6'd17, 32'h0000_1000, 8'h00, 0, 1'b0);
    wait_done("cmd17", 1500);

    // CMD55 collides with byte_start; later starts during the command are ignored.
    send_cmd(6'd55, 32'h0, 8'h00, 1, 1'b1);
    repeat (100) @(negedge clk);
    byte_tx = 8'h77; byte_start = 1'b1;
    @(negedge clk);
    byte_start = 1'b0;
    repeat (100) @(negedge clk);
    cmd_index = 6'd0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_mid_cmd", 40'(busy), 40'(1));
    wait_done("cmd55", 1000);
    repeat (2 * BYTE_CYC) @(negedge clk);
    chk("cmd55_quiet", 40'(busy), 40'(0));

    // CMD8 interrupted by reset during byte 3.
    b0 = mosi_bytes;
    for (int i = 0; i < 6; i++) card_q.push_back(8'hFF);
    exp_mosi_q.push_back(9'h048);
    exp_mosi_q.push_back(9'h000);
    exp_mosi_q.push_back(9'h000);
    @(negedge clk);
    cmd_index = 6'd8; cmd_arg = 32'h0000_01AA; cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    n = 0;
    while (mosi_bytes < b0 + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd8_reached_byte3", 40'(n < 1000), 40'(1));
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cs",      40'(mmc_cs),   40'(1));
    chk("arst_sclk",    40'(mmc_sclk), 40'(0));
    chk("arst_di",      40'(mmc_di),   40'(1));
    chk("arst_busy",    40'(busy),     40'(0));
    chk("arst_resp",    40'(resp),     40'(8'hFF));
    chk("arst_byte_rx", 40'(byte_rx),  40'(8'h00));
    card_q.delete();
    exp_mosi_q.delete();
    exp_done_q.delete();
    m_resp = 8'hFF; m_to = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    send_cmd(6'd8, 32'h0000_01AA, 8'h01, 2, 1'b0);
    wait_done("cmd8", 1000);
    repeat (10) @(negedge clk);
    chk("mosi_all_seen", 40'(exp_mosi_q.size()), 40'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
